// File: rtl/alu_mb_seq.sv
// Multi-byte ALU sequencer: takes one NBYTES-wide op, issues it byte-serially to an 8-bit ALU and assembles the result.
// Latency: response valid NBYTES+1 clocks after the accept cycle (1 clock for an illegal command).
// Backpressure: one op in flight; req_ready low from accept until the response is taken with rsp_ready.
// Optional feature: define ALU_MB_SEQ_CARRY_CHAIN_EN so byte-0 carry-in comes from the previous op's final flag.
module alu_mb_seq #(
   parameter int NBYTES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [3:0]          req_cmd,
   input  logic [8*NBYTES-1:0] req_a,
   input  logic [8*NBYTES-1:0] req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [8*NBYTES-1:0] rsp_rslt,
   output logic                rsp_sc,
   output logic                rsp_pari,
   output logic                rsp_err,
   output logic [3:0]          alu_cmd,
   output logic [7:0]          alu_inA,
   output logic [7:0]          alu_inB,
   output logic                alu_sc_i,
   input  logic [7:0]          alu_rslt,
   input  logic                alu_sc_o,
   input  logic                alu_sc_clr,
   input  logic                alu_pari
);

   localparam int W  = 8 * NBYTES;
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cmd_q;
   logic [W-1:0]    a_q, b_q;
   logic [CW-1:0]   cnt_q;
   logic            sc_flag_q;
   logic            pari_q;
   logic            err_q;
   logic [W-1:0]    rslt_q;
   logic [3:0]      alu_cmd_q;
   logic [7:0]      alu_a_q, alu_b_q;
   logic            alu_sc_q;

   logic            req_illegal;
   logic            first_sc;
   logic [3:0]      src_cmd;
   logic [W-1:0]    src_a, src_b;
   logic [CW-1:0]   iss_step;
   logic [CW-1:0]   iss_pos;
   logic [3:0]      iss_cmd;
   logic [7:0]      iss_a, iss_b;
   logic [CW-1:0]   cur_pos;

   // Shifts to the right walk from the MSB byte down so the carry flows toward the LSB.
   function automatic logic [CW-1:0] byte_pos(input logic [3:0] cmd, input logic [CW-1:0] step);
      if (cmd == 4'd3 || cmd == 4'd4) begin
         return LAST - step;
      end
      return step;
   endfunction

   // Arithmetic shift right only sign-fills the MSB byte; lower bytes take the carry as a logical shift.
   function automatic logic [3:0] byte_cmd(input logic [3:0] cmd, input logic [CW-1:0] pos);
      if (cmd == 4'd3 && pos != LAST) begin
         return 4'd4;
      end
      return cmd;
   endfunction

   assign req_illegal = (req_cmd > 4'd8);

`ifdef ALU_MB_SEQ_CARRY_CHAIN_EN
   assign first_sc = sc_flag_q;
`else
   assign first_sc = 1'b0;
`endif

   assign cur_pos = byte_pos(cmd_q, cnt_q);

   // Select the byte to present to the ALU next: the first byte of a new request, or the following byte in RUN.
   always_comb begin
      src_cmd  = cmd_q;
      src_a    = a_q;
      src_b    = b_q;
      iss_step = cnt_q + CW'(1);
      if (state_q == IDLE) begin
         src_cmd  = req_cmd;
         src_a    = req_a;
         src_b    = req_b;
         iss_step = '0;
      end
      iss_pos = byte_pos(src_cmd, iss_step);
      iss_cmd = byte_cmd(src_cmd, iss_pos);
      iss_a   = src_a[{iss_pos, 3'b000} +: 8];
      iss_b   = src_b[{iss_pos, 3'b000} +: 8];
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: illegal commands skip RUN; DONE waits for the consumer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = req_illegal ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == DONE);
   end

   // Datapath: latch the op on accept, then per RUN cycle collect one ALU byte and stage the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_q     <= 4'd0;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         sc_flag_q <= 1'b0;
         pari_q    <= 1'b0;
         err_q     <= 1'b0;
         rslt_q    <= '0;
         alu_cmd_q <= 4'd0;
         alu_a_q   <= 8'd0;
         alu_b_q   <= 8'd0;
         alu_sc_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  cmd_q  <= req_cmd;
                  a_q    <= req_a;
                  b_q    <= req_b;
                  cnt_q  <= '0;
                  pari_q <= 1'b0;
                  rslt_q <= '0;
                  err_q  <= req_illegal;
                  // An illegal op never touches the ALU, so its inputs keep the last issued byte.
                  if (!req_illegal) begin
                     alu_cmd_q <= iss_cmd;
                     alu_a_q   <= iss_a;
                     alu_b_q   <= iss_b;
                     alu_sc_q  <= first_sc;
                  end
               end
            end
            RUN: begin
               rslt_q[{cur_pos, 3'b000} +: 8] <= alu_rslt;
               sc_flag_q <= alu_sc_clr ? 1'b0 : alu_sc_o;
               pari_q    <= pari_q ^ alu_pari;
               if (cnt_q != LAST) begin
                  cnt_q     <= cnt_q + CW'(1);
                  alu_cmd_q <= iss_cmd;
                  alu_a_q   <= iss_a;
                  alu_b_q   <= iss_b;
                  // The raw ALU carry chains between bytes, independent of the clear qualifier.
                  alu_sc_q  <= alu_sc_o;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_rslt = rslt_q;
   assign rsp_sc   = sc_flag_q & ~err_q;
   assign rsp_pari = pari_q;
   assign rsp_err  = err_q;
   assign alu_cmd  = alu_cmd_q;
   assign alu_inA  = alu_a_q;
   assign alu_inB  = alu_b_q;
   assign alu_sc_i = alu_sc_q;

endmodule
